// File: rtl/usb_tx_sequencer.sv
// USB packet transmit sequencer: SYNC, PID, payload and optional CRC16 (USB_TX_CRC16_EN) as NRZI, bit-stuffed line bits.
// Latency: tx_start one cycle after launch accept, then one line bit per clock; done pulses when drv_ready returns after EOP.
// Backpressure: pkt_ready follows drv_ready in IDLE only; buffer writes are dropped while busy.
module usb_tx_sequencer #(
    parameter int MAX_BYTES = 64,
    parameter int LEN_W     = $clog2(MAX_BYTES + 1),
    parameter int ADDR_W    = $clog2(MAX_BYTES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              buf_we,
    input  logic [ADDR_W-1:0] buf_addr,
    input  logic [7:0]        buf_wdata,
    input  logic              pkt_valid,
    input  logic [3:0]        pkt_pid,
    input  logic [LEN_W-1:0]  pkt_len,
    output logic              pkt_ready,
    output logic              busy,
    output logic              done,
    output logic              tx_bit,
    output logic              tx_start,
    output logic              tx_end,
    input  logic              drv_ready
);

    localparam int CNT_W = LEN_W + 4;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

    typedef enum logic [1:0] {IDLE, START, SHIFT, WAIT_EOP} state_t;

    logic [7:0]       mem_q [MAX_BYTES];
    state_t           state_q, state_d;
    logic [3:0]       pid_q, pid_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]       stuff_q, stuff_d;
    logic             nrzi_q, nrzi_d;
    logic             busy_q, busy_d;

    logic [7:0]       pid_byte;
    logic [7:0]       rd_byte;
    logic [CNT_W-1:0] pay_end;
    logic [CNT_W-1:0] total;
    logic             field_bit;
    logic             is_stuff;
    logic             line_val;

`ifdef USB_TX_CRC16_EN
    logic [15:0] crc_q, crc_d;
    logic [3:0]  crc_off;
    logic        has_crc;

    assign has_crc = (pid_q == 4'h3) || (pid_q == 4'hB);
    assign crc_off = 4'(bit_cnt_q - pay_end);
    assign total   = pay_end + (has_crc ? CNT_W'(16) : CNT_W'(0));
`else
    assign total   = pay_end;
`endif

    assign pid_byte = {~pid_q, pid_q};
    assign pay_end  = CNT_W'(16) + CNT_W'({len_q, 3'b000});
    // Payload starts at logical bit 16, so byte index is bit_cnt/8 - 2.
    assign rd_byte  = mem_q[ADDR_W'(bit_cnt_q[CNT_W-1:3] - (CNT_W-3)'(2))];
    assign busy     = busy_q;
    assign is_stuff = (stuff_q == 3'd6);

    always_ff @(posedge clk) begin
        if (buf_we && !busy_q) begin
            mem_q[buf_addr] <= buf_wdata;
        end
    end

    always_comb begin
        field_bit = 1'b0;
        if (bit_cnt_q < CNT_W'(8)) begin
            field_bit = (bit_cnt_q[2:0] == 3'd7);
        end else if (bit_cnt_q < CNT_W'(16)) begin
            field_bit = pid_byte[bit_cnt_q[2:0]];
        end else if (bit_cnt_q < pay_end) begin
            field_bit = rd_byte[bit_cnt_q[2:0]];
`ifdef USB_TX_CRC16_EN
        end else begin
            field_bit = ~crc_q[crc_off];
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        pid_d     = pid_q;
        len_d     = len_q;
        bit_cnt_d = bit_cnt_q;
        stuff_d   = stuff_q;
        nrzi_d    = nrzi_q;
        busy_d    = busy_q;
`ifdef USB_TX_CRC16_EN
        crc_d     = crc_q;
`endif
        pkt_ready = 1'b0;
        done      = 1'b0;
        tx_start  = 1'b0;
        tx_end    = 1'b0;
        tx_bit    = 1'b1;
        line_val  = 1'b0;

        case (state_q)
            IDLE: begin
                pkt_ready = drv_ready && !rst;
                if (pkt_valid && pkt_ready) begin
                    pid_d     = pkt_pid;
                    len_d     = (pkt_len > MAX_LEN) ? MAX_LEN : pkt_len;
                    busy_d    = 1'b1;
                    bit_cnt_d = '0;
                    stuff_d   = '0;
                    nrzi_d    = 1'b1;
`ifdef USB_TX_CRC16_EN
                    crc_d     = 16'hFFFF;
`endif
                    state_d   = START;
                end
            end
            START: begin
                tx_start = 1'b1;
                state_d  = SHIFT;
            end
            SHIFT: begin
                // A stuff bit is a forced logical 0 that does not advance the stream.
                line_val = is_stuff ? 1'b0 : field_bit;
                tx_bit   = line_val ? nrzi_q : ~nrzi_q;
                nrzi_d   = tx_bit;
                stuff_d  = line_val ? stuff_q + 3'd1 : 3'd0;
                if (!is_stuff) begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
`ifdef USB_TX_CRC16_EN
                    if (bit_cnt_q >= CNT_W'(16) && bit_cnt_q < pay_end) begin
                        crc_d = {1'b0, crc_q[15:1]} ^ ((crc_q[0] ^ field_bit) ? 16'hA001 : 16'h0000);
                    end
`endif
                end
                if (is_stuff) begin
                    tx_end = (bit_cnt_q == total);
                end else begin
                    tx_end = (bit_cnt_q == total - CNT_W'(1)) && !(field_bit && stuff_q == 3'd5);
                end
                if (tx_end) begin
                    state_d = WAIT_EOP;
                end
            end
            WAIT_EOP: begin
                if (drv_ready) begin
                    done    = !rst;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pid_q     <= '0;
            len_q     <= '0;
            bit_cnt_q <= '0;
            stuff_q   <= '0;
            nrzi_q    <= 1'b1;
            busy_q    <= 1'b0;
`ifdef USB_TX_CRC16_EN
            crc_q     <= 16'hFFFF;
`endif
        end else begin
            state_q   <= state_d;
            pid_q     <= pid_d;
            len_q     <= len_d;
            bit_cnt_q <= bit_cnt_d;
            stuff_q   <= stuff_d;
            nrzi_q    <= nrzi_d;
            busy_q    <= busy_d;
`ifdef USB_TX_CRC16_EN
            crc_q     <= crc_d;
`endif
        end
    end

endmodule
